// File: rtl/uart_pkg.sv
// Shared types and constants for the USART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_tx_state_t;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_DATA_BITS_9 = 9;
  localparam int UART_BITCNT_W    = 4;

  // Index of the final data bit of a frame; the DATA state leaves on this count.
  function automatic logic [UART_BITCNT_W-1:0] last_bit_idx(input logic frame9);
    if (frame9) begin
      return UART_BITCNT_W'(UART_DATA_BITS_9 - 1);
    end else begin
      return UART_BITCNT_W'(UART_DATA_BITS - 1);
    end
  endfunction

endpackage

// File: rtl/uart_tx.sv
// Asynchronous USART transmitter: TXREG holding buffer feeding a TSR that
// shifts 8N1 or 9-bit frames LSB-first, one bit per uart_spbrg baud tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       txen,
  input  logic       tx9,
  input  logic       tx9d,
  input  logic       txreg_wr_en,
  input  logic [7:0] txreg_in,
  input  logic       uart_tx_shift_en,
  output logic       tx,
  output logic       txif,
  output logic       trmt
);

  uart_tx_state_t             r_state;
  logic [7:0]                 r_buf;
  logic                       r_buf_full;
  logic                       r_txif;
  logic [7:0]                 r_tsr;
  logic                       r_tsr9;
  logic                       r_frame9;
  logic [UART_BITCNT_W-1:0]   r_bit_cnt;
  logic                       r_tx;
  logic                       r_trmt;

  logic w_load_idle;
  logic w_load_stop;
  logic w_load;

  // A STOP-end load chains straight into the next START, giving contiguous frames.
  assign w_load_idle = txen && r_buf_full && (r_state == IDLE);
  assign w_load_stop = txen && r_buf_full && uart_tx_shift_en && (r_state == STOP);
  assign w_load      = w_load_idle || w_load_stop;

  // TXREG holding buffer; a same-cycle write wins over the drain into the TSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf      <= 8'h00;
      r_buf_full <= 1'b0;
      r_txif     <= 1'b1;
    end else if (txreg_wr_en) begin
      r_buf      <= txreg_in;
      r_buf_full <= 1'b1;
      r_txif     <= 1'b0;
    end else if (w_load) begin
      r_buf_full <= 1'b0;
      r_txif     <= 1'b1;
    end else begin
      r_buf_full <= r_buf_full;
      r_txif     <= r_txif;
    end
  end

  // Transmit FSM with TSR, bit counter and registered line/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_tsr     <= 8'h00;
      r_tsr9    <= 1'b0;
      r_frame9  <= 1'b0;
      r_bit_cnt <= '0;
      r_tx      <= IDLE_LEVEL;
      r_trmt    <= 1'b1;
    end else if (!txen) begin
      r_state   <= IDLE;
      r_tsr     <= 8'h00;
      r_tsr9    <= 1'b0;
      r_frame9  <= 1'b0;
      r_bit_cnt <= '0;
      r_tx      <= IDLE_LEVEL;
      r_trmt    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= IDLE_LEVEL;
          if (w_load_idle) begin
            r_tsr    <= r_buf;
            r_tsr9   <= tx9d;
            r_frame9 <= tx9;
            r_trmt   <= 1'b0;
            r_state  <= LOAD;
          end else begin
            r_trmt <= 1'b1;
          end
        end
        LOAD: begin
          if (uart_tx_shift_en) begin
            r_state <= START;
            r_tx    <= ~IDLE_LEVEL;
          end else begin
            r_tx <= IDLE_LEVEL;
          end
        end
        START: begin
          if (uart_tx_shift_en) begin
            r_state   <= DATA;
            r_bit_cnt <= '0;
            r_tx      <= r_tsr[0];
          end else begin
            r_tx <= ~IDLE_LEVEL;
          end
        end
        DATA: begin
          if (uart_tx_shift_en) begin
            if (r_bit_cnt == last_bit_idx(r_frame9)) begin
              r_state <= STOP;
              r_tx    <= IDLE_LEVEL;
            end else begin
              r_tsr     <= {r_frame9 & r_tsr9, r_tsr[7:1]};
              r_tx      <= r_tsr[1];
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else begin
            r_tx <= r_tsr[0];
          end
        end
        STOP: begin
          if (w_load_stop) begin
            r_tsr    <= r_buf;
            r_tsr9   <= tx9d;
            r_frame9 <= tx9;
            r_state  <= START;
            r_tx     <= ~IDLE_LEVEL;
          end else if (uart_tx_shift_en) begin
            r_state <= IDLE;
            r_trmt  <= 1'b1;
            r_tx    <= IDLE_LEVEL;
          end else begin
            r_tx <= IDLE_LEVEL;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= IDLE_LEVEL;
          r_trmt  <= 1'b1;
        end
      endcase
    end
  end

  assign tx   = r_tx;
  assign txif = r_txif;
  assign trmt = r_trmt;

endmodule
